// File: rtl/split_pkg.sv
// split_pkg: state type and lane-index width helper shared by split_stream.
package split_pkg;
    typedef enum logic {IDLE, EMIT} state_t;
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/split_stream_if.sv
// split_stream_if: wide-word input and lane output streams of split_stream.
// in_keep exists only when SPLIT_STREAM_KEEP_EN is defined.
interface split_stream_if #(
    parameter int LANE_W = 1,
    parameter int LANES  = 8
);
    logic [LANES*LANE_W-1:0]            in_data;
    logic                               in_valid;
    logic                               in_ready;
`ifdef SPLIT_STREAM_KEEP_EN
    logic [LANES-1:0]                   in_keep;
`endif
    logic [LANE_W-1:0]                  out_data;
    logic                               out_valid;
    logic                               out_ready;
    logic                               out_last;
    logic [split_pkg::idx_w(LANES)-1:0] out_idx;
`ifdef SPLIT_STREAM_KEEP_EN
    modport slave (input in_data, in_valid, in_keep, out_ready,
                   output in_ready, out_data, out_valid, out_last, out_idx);
    modport master (output in_data, in_valid, in_keep, out_ready,
                    input in_ready, out_data, out_valid, out_last, out_idx);
`else
    modport slave (input in_data, in_valid, out_ready,
                   output in_ready, out_data, out_valid, out_last, out_idx);
    modport master (output in_data, in_valid, out_ready,
                    input in_ready, out_data, out_valid, out_last, out_idx);
`endif
endinterface

// File: rtl/split_next_lane.sv
// split_next_lane: picks the next pending lane from a mask, lowest first or highest first.
module split_next_lane import split_pkg::*; #(
    parameter int LANES     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic [LANES-1:0]          mask,
    output logic [idx_w(LANES)-1:0]   idx
);
    localparam int IW = idx_w(LANES);
    // later hits overwrite earlier ones, so scan away from the preferred end
    always_comb begin
        idx = '0;
        for (int i = 0; i < LANES; i++)
            if (mask[(MSB_FIRST != 0) ? i : LANES - 1 - i])
                idx = IW'((MSB_FIRST != 0) ? i : LANES - 1 - i);
    end
endmodule

// File: rtl/split_stream.sv
// split_stream: serialises one held wide word into LANE_W-bit lanes, one per output transfer.
// Define SPLIT_STREAM_KEEP_EN to add in_keep and skip lanes whose keep bit is clear.
module split_stream import split_pkg::*; #(
    parameter int LANE_W    = 1,
    parameter int LANES     = 8,
    parameter int MSB_FIRST = 0
) (
    input logic           clk,
    input logic           rst_n,
    split_stream_if.slave s
);
    localparam int IW = idx_w(LANES);
    state_t                  state, state_nx;
    logic [LANES*LANE_W-1:0] word;
    logic [IW-1:0]           lane;
    logic                    last, emit, in_fire, out_fire, load;
    assign emit     = state == EMIT;
    assign in_fire  = s.in_valid && s.in_ready;
    assign out_fire = emit && s.out_ready;
`ifdef SPLIT_STREAM_KEEP_EN
    logic [LANES-1:0] rem, rem_nx;
    split_next_lane #(.LANES(LANES), .MSB_FIRST(MSB_FIRST)) u_next (
        .mask (rem),
        .idx  (lane)
    );
    assign rem_nx = rem & ~(LANES'(1) << lane);
    assign last   = rem_nx == '0;
    // an all-zero keep word is accepted but never occupies the register
    assign load   = in_fire && |s.in_keep;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rem <= '0;
        else if (load) rem <= s.in_keep;
        else if (out_fire) rem <= rem_nx;
`else
    logic [IW-1:0] cnt;
    assign lane = (MSB_FIRST != 0) ? IW'(LANES - 1) - cnt : cnt;
    assign last = cnt == IW'(LANES - 1);
    assign load = in_fire;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= '0;
        else if (out_fire) cnt <= cnt + 1'b1;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            word  <= '0;
        end else begin
            state <= state_nx;
            if (load) word <= s.in_data;
        end
    always_comb begin
        state_nx = state;
        if (load) state_nx = EMIT;
        else if (out_fire && last) state_nx = IDLE;
    end
    assign s.in_ready  = !emit || (s.out_ready && last);
    assign s.out_valid = emit;
    assign s.out_last  = emit && last;
    assign s.out_idx   = emit ? lane : '0;
    assign s.out_data  = emit ? word[lane*LANE_W +: LANE_W] : '0;
endmodule

// File: tb/tb_split_stream.sv
// tb_split_stream: directed and randomized checks of split_stream against a lane-queue model.
// Keep-mask scenarios are added when SPLIT_STREAM_KEEP_EN is defined.
module tb_split_stream;
    logic clk = 0, rst_n = 0;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    split_stream_if #(.LANE_W(1), .LANES(8)) a_if ();
    split_stream_if #(.LANE_W(4), .LANES(4)) b_if ();
    split_stream #(.LANE_W(1), .LANES(8), .MSB_FIRST(0)) dut_a (.clk(clk), .rst_n(rst_n), .s(a_if.slave));
    split_stream #(.LANE_W(4), .LANES(4), .MSB_FIRST(1)) dut_b (.clk(clk), .rst_n(rst_n), .s(b_if.slave));
    typedef struct packed {logic d; logic [2:0] idx; logic last;} lane_t;

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic settle(); #1; endtask

    task automatic test_reset();
        a_if.in_valid = 0; a_if.out_ready = 0; a_if.in_data = '0;
        b_if.in_valid = 0; b_if.out_ready = 0; b_if.in_data = '0;
`ifdef SPLIT_STREAM_KEEP_EN
        a_if.in_keep = 8'hFF; b_if.in_keep = 4'hF;
`endif
        rst_n = 0; #23 rst_n = 1;
        tick(); settle();
        n_chk++;
        if ({a_if.out_valid, a_if.out_last, a_if.out_idx, a_if.out_data, a_if.in_ready} !== 7'b0000001) begin
            n_fail++; $display("FAIL reset_a got v%b l%b i%0d d%b r%b want 0 0 0 0 1", a_if.out_valid, a_if.out_last, a_if.out_idx, a_if.out_data, a_if.in_ready);
        end
        n_chk++;
        if ({b_if.out_valid, b_if.out_last, b_if.out_idx, b_if.out_data, b_if.in_ready} !== 9'b000000001) begin
            n_fail++; $display("FAIL reset_b got v%b l%b i%0d d%h r%b want 0 0 0 0 1", b_if.out_valid, b_if.out_last, b_if.out_idx, b_if.out_data, b_if.in_ready);
        end
    endtask

    task automatic test_lsb_order();
        logic [7:0] w;
        w = 8'hA5;
        tick(); a_if.in_data = w; a_if.in_valid = 1; a_if.out_ready = 1; settle();
        n_chk++;
        if (a_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL order_in_ready got %b want 1", a_if.in_ready); end
        for (int i = 0; i < 8; i++) begin
            tick(); a_if.in_valid = 0; settle();
            n_chk++;
            if ({a_if.out_valid, a_if.out_data, a_if.out_idx, a_if.out_last} !== {1'b1, w[i], 3'(i), i == 7}) begin
                n_fail++; $display("FAIL order_lane%0d got v%b d%b i%0d l%b want 1 %b %0d %b", i, a_if.out_valid, a_if.out_data, a_if.out_idx, a_if.out_last, w[i], i, i == 7);
            end
        end
        tick(); settle();
        n_chk++;
        if ({a_if.out_valid, a_if.in_ready} !== 2'b01) begin n_fail++; $display("FAIL order_idle got v%b r%b want 0 1", a_if.out_valid, a_if.in_ready); end
    endtask

    task automatic test_stall();
        logic [7:0] w;
        int k = 0;
        w = 8'hA5;
        tick(); a_if.in_data = w; a_if.in_valid = 1; a_if.out_ready = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            tick(); a_if.in_valid = 0; a_if.out_ready = (c % 4 == 0) || (c % 4 == 3); settle();
            n_chk++;
            if ({a_if.out_valid, a_if.out_data, a_if.out_idx, a_if.out_last} !== {1'b1, w[k], 3'(k), k == 7}) begin
                n_fail++; $display("FAIL stall_c%0d got v%b d%b i%0d l%b want 1 %b %0d %b", c, a_if.out_valid, a_if.out_data, a_if.out_idx, a_if.out_last, w[k], k, k == 7);
            end
            if (a_if.out_ready) k++;
        end
        n_chk++;
        if (k != 8) begin n_fail++; $display("FAIL stall_count got %0d want 8", k); end
        tick(); a_if.out_ready = 1; settle();
        n_chk++;
        if (a_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_extra got v%b want 0", a_if.out_valid); end
    endtask

    task automatic test_reset_mid();
        tick(); a_if.in_data = 8'hFF; a_if.in_valid = 1; a_if.out_ready = 1;
        tick(); a_if.in_valid = 0;
        repeat (3) tick();
        settle();
        n_chk++;
        if ({a_if.out_valid, a_if.out_idx} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL midrst_pre got v%b i%0d want 1 3", a_if.out_valid, a_if.out_idx); end
        rst_n = 0; settle();
        n_chk++;
        if ({a_if.out_valid, a_if.out_last, a_if.out_idx, a_if.out_data} !== 6'b0) begin
            n_fail++; $display("FAIL midrst_async got v%b l%b i%0d d%b want 0 0 0 0", a_if.out_valid, a_if.out_last, a_if.out_idx, a_if.out_data);
        end
        tick(); rst_n = 1; settle();
        n_chk++;
        if ({a_if.in_ready, a_if.out_valid} !== 2'b10) begin n_fail++; $display("FAIL midrst_release got r%b v%b want 1 0", a_if.in_ready, a_if.out_valid); end
        tick(); a_if.in_data = 8'hA5; a_if.in_valid = 1;
        tick(); a_if.in_valid = 0; settle();
        n_chk++;
        if ({a_if.out_valid, a_if.out_data, a_if.out_idx} !== {1'b1, 1'b1, 3'd0}) begin
            n_fail++; $display("FAIL midrst_next got v%b d%b i%0d want 1 1 0", a_if.out_valid, a_if.out_data, a_if.out_idx);
        end
        repeat (8) tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [2];
        logic [15:0] w;
        logic [3:0]  nib;
        int wi = 0, ln;
        logic fired;
        words[0] = 16'h1234; words[1] = 16'hABCD;
        tick(); b_if.out_ready = 1; b_if.in_data = words[0]; b_if.in_valid = 1; settle();
        fired = b_if.in_ready;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (fired) begin
                wi++;
                b_if.in_valid = wi < 2;
                if (wi < 2) b_if.in_data = words[wi];
            end
            settle();
            fired = b_if.in_valid && b_if.in_ready;
            w = words[c / 4]; ln = 3 - c % 4; nib = w[ln*4 +: 4];
            n_chk++;
            if ({b_if.out_valid, b_if.out_data, b_if.out_idx, b_if.out_last, b_if.in_ready} !== {1'b1, nib, 2'(ln), c % 4 == 3, c % 4 == 3}) begin
                n_fail++; $display("FAIL b2b_c%0d got v%b d%h i%0d l%b r%b want 1 %h %0d %b %b", c, b_if.out_valid, b_if.out_data, b_if.out_idx, b_if.out_last, b_if.in_ready, nib, ln, c % 4 == 3, c % 4 == 3);
            end
        end
        tick(); settle();
        n_chk++;
        if (b_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got v%b want 0", b_if.out_valid); end
    endtask

`ifdef SPLIT_STREAM_KEEP_EN
    task automatic test_keep();
        int exp_idx [3];
        logic [7:0] w;
        exp_idx[0] = 1; exp_idx[1] = 4; exp_idx[2] = 7;
        w = 8'hF0;
        tick(); a_if.in_data = w; a_if.in_keep = 8'b1001_0010; a_if.in_valid = 1; a_if.out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); a_if.in_valid = 0; settle();
            n_chk++;
            if ({a_if.out_valid, a_if.out_data, a_if.out_idx, a_if.out_last} !== {1'b1, w[exp_idx[i]], 3'(exp_idx[i]), i == 2}) begin
                n_fail++; $display("FAIL keep_lane%0d got v%b d%b i%0d l%b want 1 %b %0d %b", i, a_if.out_valid, a_if.out_data, a_if.out_idx, a_if.out_last, w[exp_idx[i]], exp_idx[i], i == 2);
            end
        end
        tick(); a_if.in_keep = 8'h00; a_if.in_valid = 1; settle();
        for (int c = 0; c < 4; c++) begin
            tick(); a_if.in_valid = 0; settle();
            n_chk++;
            if ({a_if.out_valid, a_if.in_ready} !== 2'b01) begin n_fail++; $display("FAIL keep_zero_c%0d got v%b r%b want 0 1", c, a_if.out_valid, a_if.in_ready); end
        end
        a_if.in_keep = 8'hFF;
    endtask
`endif

    task automatic test_random();
        lane_t q[$];
        lane_t h;
        logic [7:0] k;
        logic exp_r, exp_v;
        int lk;
        for (int c = 0; c < 400; c++) begin
            tick();
            a_if.in_valid  = (c < 360) && ($urandom_range(0, 1) == 1);
            a_if.in_data   = 8'($urandom);
            a_if.out_ready = (c >= 360) || ($urandom_range(0, 3) != 0);
            k = 8'hFF;
`ifdef SPLIT_STREAM_KEEP_EN
            a_if.in_keep = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            k = a_if.in_keep;
`endif
            settle();
            exp_v = q.size() != 0;
            exp_r = q.size() == 0 || (q.size() == 1 && a_if.out_ready);
            n_chk++;
            if ({a_if.out_valid, a_if.in_ready} !== {exp_v, exp_r}) begin
                n_fail++; $display("FAIL rand_hs_c%0d got v%b r%b want %b %b", c, a_if.out_valid, a_if.in_ready, exp_v, exp_r);
            end
            if (a_if.out_valid && a_if.out_ready && q.size() > 0) begin
                h = q.pop_front();
                n_chk++;
                if ({a_if.out_data, a_if.out_idx, a_if.out_last} !== {h.d, h.idx, h.last}) begin
                    n_fail++; $display("FAIL rand_lane_c%0d got d%b i%0d l%b want %b %0d %b", c, a_if.out_data, a_if.out_idx, a_if.out_last, h.d, h.idx, h.last);
                end
            end
            if (a_if.in_valid && a_if.in_ready) begin
                lk = -1;
                for (int i = 0; i < 8; i++) if (k[i]) lk = i;
                for (int i = 0; i < 8; i++) if (k[i]) q.push_back('{a_if.in_data[i], 3'(i), i == lk});
            end
        end
        n_chk++;
        if (q.size() != 0) begin n_fail++; $display("FAIL rand_drain got %0d pending want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_lsb_order();
        test_stall();
        test_reset_mid();
        test_back_to_back();
`ifdef SPLIT_STREAM_KEEP_EN
        test_keep();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
